rr_arb4: RTL and testbench

Four-requester round-robin arbiter that shares one downstream resource between four clients. It resolves contention with a rotating-priority search built on a 4-bit priority encoder, holds the grant while the owner keeps requesting, and forces preemption after a bounded hold time when others are waiting. It sits between the client request lines and the shared datapath's select/enable inputs.

---
 rtl/arb_pkg.sv | 21 ++
 rtl/prenc_lsb4.sv | 25 ++
 rtl/rr_arb4.sv | 113 +++++++++++
 tb/tb_rr_arb4.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the four-way round-robin arbiter.
// Holds the requester count, index width, state encoding and the rotate helper.
package arb_pkg;

    localparam int NREQ  = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;

    // Rotates right so that bit 'sh' of the input lands at bit 0.
    function automatic logic [NREQ-1:0] rotr(input logic [NREQ-1:0] v,
                                             input logic [IDX_W-1:0] sh);
        logic [2*NREQ-1:0] doubled;
        doubled = {v, v} >> sh;
        return doubled[NREQ-1:0];
    endfunction

endpackage

// File: rtl/prenc_lsb4.sv
// Four-bit priority encoder: the lowest set bit wins.
// vld is low when no bit is set; idx is then zero.
module prenc_lsb4 (
    input  logic [3:0] req,
    output logic [1:0] idx,
    output logic       vld
);

    always_comb begin
        idx = 2'd0;
        vld = 1'b1;
        if (req[0]) begin
            idx = 2'd0;
        end else if (req[1]) begin
            idx = 2'd1;
        end else if (req[2]) begin
            idx = 2'd2;
        end else if (req[3]) begin
            idx = 2'd3;
        end else begin
            vld = 1'b0;
        end
    end

endmodule

// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter with grant hold and bounded-hold preemption.
// The search starts at ptr; the current owner is masked out so a handover never re-picks it.
module rr_arb4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic [7:0]       busy_cnt
);

    localparam logic [7:0] MaxHold = 8'(MAX_HOLD);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [7:0]       busyCnt_q, busyCnt_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             gntVld_q, gntVld_d;

    logic [NREQ-1:0]  ownerMask;
    logic [NREQ-1:0]  searchReq;
    logic [NREQ-1:0]  rotReq;
    logic [IDX_W-1:0] encIdx;
    logic             encVld;
    logic [IDX_W-1:0] winner;
    logic             releaseGnt;

    // In IDLE the mask is empty, so the same search serves both first grant and handover.
    always_comb begin
        ownerMask = (state_q == GRANT) ? (4'b0001 << owner_q) : 4'b0000;
        searchReq = req & ~ownerMask;
        rotReq    = rotr(searchReq, ptr_q);
        winner    = encIdx + ptr_q;
        releaseGnt = (state_q == GRANT) &&
                     (!req[owner_q] || ((busyCnt_q >= MaxHold) && (|searchReq)));
    end

    prenc_lsb4 u_prenc (
        .req (rotReq),
        .idx (encIdx),
        .vld (encVld)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        busyCnt_d = busyCnt_q;
        gnt_d     = gnt_q;
        gntVld_d  = gntVld_q;
        case (state_q)
            IDLE: begin
                if (encVld) begin
                    state_d   = GRANT;
                    owner_d   = winner;
                    busyCnt_d = 8'd1;
                    gnt_d     = 4'b0001 << winner;
                    gntVld_d  = 1'b1;
                end
            end
            GRANT: begin
                if (!releaseGnt) begin
                    busyCnt_d = (busyCnt_q == 8'hFF) ? busyCnt_q : busyCnt_q + 8'd1;
                end else begin
                    ptr_d = owner_q + 2'd1;
                    if (encVld) begin
                        owner_d   = winner;
                        busyCnt_d = 8'd1;
                        gnt_d     = 4'b0001 << winner;
                    end else begin
                        state_d   = IDLE;
                        busyCnt_d = 8'd0;
                        gnt_d     = 4'b0000;
                        gntVld_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            busyCnt_q <= '0;
            gnt_q     <= '0;
            gntVld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            busyCnt_q <= busyCnt_d;
            gnt_q     <= gnt_d;
            gntVld_q  <= gntVld_d;
        end
    end

    assign gnt      = gnt_q;
    assign gnt_idx  = owner_q;
    assign gnt_vld  = gntVld_q;
    assign busy_cnt = busyCnt_q;

endmodule

// File: tb/tb_rr_arb4.sv
// Self-checking bench for rr_arb4: two instances (hold limits 8 and 2) share one request bus
// and are compared every cycle against a queue-free behavioural model of the arbitration rules.
module tb_rr_arb4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;

    logic [3:0] gnt8, gnt2;
    logic [1:0] idx8, idx2;
    logic       vld8, vld2;
    logic [7:0] cnt8, cnt2;

    typedef struct {
        int owner;
        int ptr;
        int cnt;
        int lastIdx;
    } model_t;

    model_t m8, m2;
    int     checks   = 0;
    int     failures = 0;
    bit     checkEn  = 1'b0;

    always #5 clk = ~clk;

    rr_arb4 #(.MAX_HOLD(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt8), .gnt_idx(idx8), .gnt_vld(vld8), .busy_cnt(cnt8)
    );

    rr_arb4 #(.MAX_HOLD(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt2), .gnt_idx(idx2), .gnt_vld(vld2), .busy_cnt(cnt2)
    );

    function automatic model_t modelReset();
        model_t s;
        s.owner   = -1;
        s.ptr     = 0;
        s.cnt     = 0;
        s.lastIdx = 0;
        return s;
    endfunction

    // First requester found walking p, p+1, p+2, p+3 around the ring.
    function automatic int pickNext(input logic [3:0] cand, input int p);
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (p + k) % 4;
            if (cand[c]) return c;
        end
        return -1;
    endfunction

    function automatic model_t modelStep(input model_t s, input logic [3:0] r, input int maxHold);
        model_t     n;
        logic [3:0] others;
        n = s;
        if (s.owner < 0) begin
            n.owner = pickNext(r, s.ptr);
            if (n.owner >= 0) begin
                n.cnt     = 1;
                n.lastIdx = n.owner;
            end
        end else begin
            others           = r;
            others[s.owner]  = 1'b0;
            if (r[s.owner] && !(s.cnt >= maxHold && others != 4'b0000)) begin
                n.cnt = (s.cnt < 255) ? s.cnt + 1 : 255;
            end else begin
                n.ptr   = (s.owner + 1) % 4;
                n.owner = pickNext(others, s.ptr);
                if (n.owner >= 0) begin
                    n.cnt     = 1;
                    n.lastIdx = n.owner;
                end else begin
                    n.cnt = 0;
                end
            end
        end
        return n;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic compareModel(input string tag, input model_t s, input logic [3:0] g,
                                input logic [1:0] idx, input logic v, input logic [7:0] c);
        int expGnt;
        expGnt = (s.owner >= 0) ? (1 << s.owner) : 0;
        checkOutput({tag, " gnt"}, int'(g), expGnt);
        checkOutput({tag, " gnt_vld"}, int'(v), (s.owner >= 0) ? 1 : 0);
        checkOutput({tag, " gnt_idx"}, int'(idx), (s.owner >= 0) ? s.owner : s.lastIdx);
        if (s.owner >= 0) checkOutput({tag, " busy_cnt"}, int'(c), s.cnt);
    endtask

    // Model advances on every clock edge and on async reset; outputs compared 1 time unit later.
    always begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m8 = modelReset();
            m2 = modelReset();
        end else begin
            m8 = modelStep(m8, req, 8);
            m2 = modelStep(m2, req, 2);
        end
        #1;
        if (checkEn) begin
            compareModel("model8", m8, gnt8, idx8, vld8, cnt8);
            compareModel("model2", m2, gnt2, idx2, vld2, cnt2);
        end
    end

    task automatic applyStimulus(input logic [3:0] r);
        @(negedge clk);
        req = r;
        @(posedge clk);
        #2;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int expOwn [9];
        int expCnt [9];
        logic [3:0] r;
        expOwn = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
        expCnt = '{1, 2, 1, 2, 1, 2, 1, 2, 1};

        m8    = modelReset();
        m2    = modelReset();
        rst_n = 1'b0;
        req   = 4'b0000;
        @(posedge clk);
        #2;
        checkEn = 1'b1;
        checkOutput("reset gnt", int'(gnt8), 0);
        checkOutput("reset gnt_vld", int'(vld8), 0);
        checkOutput("reset gnt_idx", int'(idx8), 0);
        checkOutput("reset busy_cnt", int'(cnt8), 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] single requester");
        applyStimulus(4'b0100);
        checkOutput("single gnt", int'(gnt8), 4);
        checkOutput("single gnt_idx", int'(idx8), 2);
        checkOutput("single gnt_vld", int'(vld8), 1);
        applyStimulus(4'b0000);
        checkOutput("single drop gnt", int'(gnt8), 0);
        checkOutput("single drop idx held", int'(idx8), 2);

        $display("[TB] fairness with hold limit 2");
        doReset();
        for (int i = 0; i < 9; i++) begin
            applyStimulus(4'b1111);
            checkOutput("fair owner", int'(idx2), expOwn[i]);
            checkOutput("fair gnt", int'(gnt2), 1 << expOwn[i]);
            checkOutput("fair busy_cnt", int'(cnt2), expCnt[i]);
        end

        $display("[TB] voluntary release");
        doReset();
        applyStimulus(4'b0010);
        checkOutput("vol first gnt", int'(gnt8), 2);
        applyStimulus(4'b1000);
        checkOutput("vol handover gnt", int'(gnt8), 8);
        checkOutput("vol handover idx", int'(idx8), 3);
        checkOutput("vol handover busy_cnt", int'(cnt8), 1);

        $display("[TB] timeout without contention and saturation");
        doReset();
        for (int i = 0; i < 260; i++) begin
            applyStimulus(4'b0001);
            if (i == 19) begin
                checkOutput("solo gnt", int'(gnt8), 1);
                checkOutput("solo busy_cnt 20", int'(cnt8), 20);
            end
        end
        checkOutput("solo busy_cnt saturated", int'(cnt8), 255);

        $display("[TB] pointer wrap");
        doReset();
        for (int i = 0; i < 8; i++) applyStimulus(4'b1000);
        checkOutput("wrap owner3 busy_cnt", int'(cnt8), 8);
        applyStimulus(4'b1001);
        checkOutput("wrap gnt", int'(gnt8), 1);
        checkOutput("wrap idx", int'(idx8), 0);

        $display("[TB] async reset mid-grant");
        doReset();
        applyStimulus(4'b0100);
        checkOutput("areset pre gnt", int'(gnt8), 4);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("areset gnt", int'(gnt8), 0);
        checkOutput("areset gnt_vld", int'(vld8), 0);
        checkOutput("areset busy_cnt", int'(cnt8), 0);
        @(negedge clk);
        req   = 4'b1111;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        checkOutput("areset first owner", int'(gnt8), 1);

        $display("[TB] randomized traffic");
        r = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) r = 4'($urandom_range(0, 15));
            applyStimulus(r);
            if ($urandom_range(0, 299) == 0) begin
                #1;
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
